// File: rtl/control_types.sv
// Shared types for the fetch-side branch predictor: BTB entry layout and
// 2-bit saturating direction counter helpers.
package control_types;

   localparam int unsigned PC_W  = 32;
   // Tag container sized for the smallest legal BTB (4 entries); larger BTBs zero-extend.
   localparam int unsigned TAG_W = PC_W - 4;

   localparam logic [1:0] CTR_SNT = 2'd0;
   localparam logic [1:0] CTR_WNT = 2'd1;
   localparam logic [1:0] CTR_WT  = 2'd2;
   localparam logic [1:0] CTR_ST  = 2'd3;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [PC_W-1:0]   target;
      logic [1:0]        ctr;
   } btb_entry_t;

   function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      case (ctr)
         CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
         CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
         CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
         default: nxt = taken ? CTR_ST  : CTR_WT;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped BTB storage: two combinational read ports, one synchronous
// write port; only the valid bits are reset.
module btb_array
   import control_types::*;
#(
   parameter int unsigned ENTRIES = 64,
   parameter int unsigned IDX_W   = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_a_idx,
   output btb_entry_t       rd_a_entry,
   input  logic [IDX_W-1:0] rd_b_idx,
   output btb_entry_t       rd_b_entry,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  btb_entry_t       wr_entry
);

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [PC_W-1:0]    target_q [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= wr_entry.valid;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_idx]    <= wr_entry.tag;
         target_q[wr_idx] <= wr_entry.target;
         ctr_q[wr_idx]    <= wr_entry.ctr;
      end
   end

   // Reads see pre-write contents; a same-cycle write shows up next cycle.
   always_comb begin
      rd_a_entry.valid  = valid_q[rd_a_idx];
      rd_a_entry.tag    = tag_q[rd_a_idx];
      rd_a_entry.target = target_q[rd_a_idx];
      rd_a_entry.ctr    = ctr_q[rd_a_idx];
      rd_b_entry.valid  = valid_q[rd_b_idx];
      rd_b_entry.tag    = tag_q[rd_b_idx];
      rd_b_entry.target = target_q[rd_b_idx];
      rd_b_entry.ctr    = ctr_q[rd_b_idx];
   end

endmodule

// File: rtl/branch_target_predictor.sv
// IF-stage PC owner: BTB lookup at fetch, EX-stage resolution, mispredict
// redirect/flush and BTB training.
module branch_target_predictor
   import control_types::*;
#(
   parameter int unsigned    XLEN        = PC_W,
   parameter int unsigned    BTB_ENTRIES = 64,
   parameter logic [XLEN-1:0] RESET_PC   = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   output logic [XLEN-1:0] if_pc,
   output logic            if_pred_taken,
   output logic [XLEN-1:0] if_pred_target,
   input  logic            ex_valid,
   input  logic            ex_is_jump,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            ex_taken,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_target,
   output logic            redirect,
   output logic            flush_if_id,
   output logic            flush_id_ex
);

   localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);

   logic [IDX_W-1:0] if_idx;
   logic [IDX_W-1:0] ex_idx;
   logic [TAG_W-1:0] if_tag;
   logic [TAG_W-1:0] ex_tag;
   btb_entry_t       if_entry;
   btb_entry_t       ex_entry;
   btb_entry_t       wr_entry;
   logic             wr_en;
   logic             if_hit;
   logic             ex_hit;
   logic             act;
   logic             mis;
   logic [XLEN-1:0]  pc_d;

   assign if_idx = if_pc[IDX_W+1:2];
   assign ex_idx = ex_pc[IDX_W+1:2];
   assign if_tag = TAG_W'(if_pc[XLEN-1:IDX_W+2]);
   assign ex_tag = TAG_W'(ex_pc[XLEN-1:IDX_W+2]);

   btb_array #(
      .ENTRIES (BTB_ENTRIES),
      .IDX_W   (IDX_W)
   ) u_btb (
      .clk        (clk),
      .rst        (rst),
      .rd_a_idx   (if_idx),
      .rd_a_entry (if_entry),
      .rd_b_idx   (ex_idx),
      .rd_b_entry (ex_entry),
      .wr_en      (wr_en),
      .wr_idx     (ex_idx),
      .wr_entry   (wr_entry)
   );

   // Fetch-side lookup
   assign if_hit         = if_entry.valid && (if_entry.tag == if_tag);
   assign if_pred_taken  = if_hit && if_entry.ctr[1];
   assign if_pred_target = if_pred_taken ? XLEN'(if_entry.target) : '0;

   // EX-side resolution
   assign act = ex_is_jump | ex_taken;
   assign mis = (act != ex_pred_taken) ||
                (act && ex_pred_taken && (ex_target != ex_pred_target));

   assign redirect    = ex_valid && mis && !rst;
   assign flush_if_id = redirect;
   assign flush_id_ex = redirect;

   // Training: update on hit, allocate on taken miss, nothing on not-taken miss.
   assign ex_hit = ex_entry.valid && (ex_entry.tag == ex_tag);

   always_comb begin
      wr_en           = ex_valid && !rst && (ex_hit || act);
      wr_entry.valid  = 1'b1;
      wr_entry.tag    = ex_tag;
      wr_entry.target = PC_W'(ex_target);
      wr_entry.ctr    = CTR_WT;
      if (ex_hit) begin
         wr_entry.ctr = sat_update(ex_entry.ctr, act);
         if (!act) begin
            wr_entry.target = ex_entry.target;
         end
      end
   end

   // Next-PC priority: redirect, stall, prediction, sequential.
   always_comb begin
      pc_d = if_pc + XLEN'(4);
      if (redirect) begin
         pc_d = act ? ex_target : (ex_pc + XLEN'(4));
      end else if (stall) begin
         pc_d = if_pc;
      end else if (if_pred_taken) begin
         pc_d = if_pred_target;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         if_pc <= RESET_PC;
      end else begin
         if_pc <= pc_d;
      end
   end

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Fetch-side next-PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It owns the IF-stage PC and predicts taken branches and jumps at fetch. It consumes the resolved outcome from the EX-stage branch comparator and target adder. On a mispredict it redirects the PC, flushes the wrong-path IF/ID and ID/EX contents, and trains the BTB.

## Interface
Parameters:
- XLEN, 32, datapath/PC width
- BTB_ENTRIES, 64, entry count; power of two, ≥ 4
- RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- stall  in  1  hazard-unit hold; freezes PC
- if_pc  out  XLEN  current fetch address (registered)
- if_pred_taken  out  1  BTB hit with counter[1]=1 for if_pc
- if_pred_target  out  XLEN  predicted target; 0 when if_pred_taken=0
- ex_valid  in  1  EX holds a valid branch or jump
- ex_is_jump  in  1  JAL/JALR; outcome is always taken
- ex_pc  in  XLEN  PC of the EX instruction
- ex_taken  in  1  branch comparator result; ignored when ex_is_jump=1
- ex_target  in  XLEN  resolved target
- ex_pred_taken  in  1  if_pred_taken carried through the pipeline
- ex_pred_target  in  XLEN  if_pred_target carried through the pipeline
- redirect  out  1  mispredict this cycle
- flush_if_id  out  1  bubble the IF/ID register at the next edge
- flush_id_ex  out  1  bubble the ID/EX register at the next edge

## Operation
Address fields:
- idx = pc[IDX_W+1:2], where IDX_W = $clog2(BTB_ENTRIES)
- tag = pc[XLEN-1:IDX_W+2]

Entry contents: valid, tag, target, 2-bit counter.

Lookup (combinational on if_pc):
- Hit = valid && tag match.
- if_pred_taken = hit && ctr[1].

Resolution, computed only when ex_valid=1:
- Actual taken: act = ex_is_jump | ex_taken.
- Mispredict: mis = (act != ex_pred_taken) || (act && ex_pred_taken && ex_target != ex_pred_target).
- redirect = flush_if_id = flush_id_ex = ex_valid && mis. All three are combinational and forced to 0 while rst=1.

Next-PC selection, highest priority first:
1. rst: RESET_PC.
2. redirect: ex_target if act, else ex_pc + 4.
3. stall: hold the current if_pc.
4. if_pred_taken: if_pred_target.
5. Otherwise: if_pc + 4, wrapping modulo 2^XLEN.

Training happens at the clock edge when ex_valid=1, regardless of stall:
- **Hit, taken:** ctr = min(ctr+1, 3); target = ex_target.
- **Hit, not taken:** ctr = max(ctr-1, 0).
- **Miss, taken:** allocate the entry, overwriting any existing one. Set valid=1, tag, target, ctr=2'b10.
- **Miss, not taken:** no write.

Simultaneous lookup and write to the same idx:
- The lookup returns the pre-write contents.
- The write becomes visible in the next cycle.

## Timing
- Reset: held ≥ 1 cycle. It clears every valid bit, sets if_pc = RESET_PC, and leaves counters and targets don't-care. At the first edge after reset deasserts, if_pc advances to RESET_PC + 4, or stays put if stall=1.
- Reset asserted mid-operation overrides any redirect or training in that cycle; no BTB write occurs.
- Prediction latency: 0 cycles. The lookup takes effect at the next edge, so fetch is bubble-free on a correct taken prediction.
- Mispredict penalty: 2 cycles. The two instructions in IF/ID and ID/EX are flushed, and the correct target is fetched in the cycle after the EX cycle.
- Flush signals are high for exactly the one cycle in which the mispredicting instruction is in EX.
- No handshake with the surrounding pipeline. The EX inputs are sampled every cycle and qualified only by ex_valid.

## Structure
- Shared package (control_types): btb_entry_t struct (valid, tag, target, ctr), counter constants CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3, and a sat_update function.
- Sub-module btb_array:
  - Flop array with combinational read and a synchronous write port.
  - Only valid bits are reset.
- Top level holds the PC register, the resolve/mispredict logic and the next-PC mux.

## Test plan
- **Reset and sequential fetch:** rst high for 2 cycles, then low with no ex_valid. Expected: if_pc = 0x0, 0x4, 0x8, 0xC; if_pred_taken=0 throughout.
- **Cold taken branch:** ex_pc=0x10, ex_taken=1, ex_target=0x40, ex_pred_taken=0. Expected:
  - redirect and both flushes high for 1 cycle; next if_pc=0x40.
  - On a later fetch of 0x10: if_pred_taken=1, if_pred_target=0x40, and the following if_pc=0x40.
- **Counter hysteresis:** train 0x10 taken 3 more times (ctr=3), then one not-taken, which mispredicts and redirects to 0x14. Expected: 0x10 still predicted taken (ctr=2). After a second not-taken (ctr=1): if_pred_taken=0.
- **Target change on hit:** JALR at 0x20, predicted taken to 0x80, resolves to 0x90. Expected: redirect to 0x90; the next lookup of 0x20 returns target 0x90.
- **Aliasing:** with BTB_ENTRIES=64, allocate 0x10, then fetch 0x110 (same idx, different tag). Expected: miss, if_pred_taken=0. A taken 0x110 then evicts the 0x10 entry.
- **Stall interaction:**
  - stall=1 for 3 cycles: if_pc holds.
  - stall=1 coinciding with a mispredict: redirect wins and if_pc takes the corrected target.
  - rst=1 coinciding with a mispredict: if_pc=RESET_PC and no BTB write.
